// File: rtl/rip_regfile_scoreboard_if.sv
// Bundle between decode/write-back and the RAW hazard scoreboard.
// master: the pipeline side (drives issue/retire/flush, observes readiness and status).
// slave : the scoreboard (consumes issue/retire/flush, produces de_ready and status).
//   issue_valid/issue_wen/issue_rd_num : decode instruction and its destination
//   if_rs1_num/if_rs2_num, rs1_used/rs2_used : its source registers
//   retire_valid/retire_rd_num : register write-back this cycle
//   flush : discard all in-flight writes
//   de_ready : decode may advance / register file samples sources
//   busy_mask : per-register pending-write flag
//   err_underflow : sticky retire-without-pending error
//   stall_cycles : saturating stall counter
interface rip_regfile_scoreboard_if #(
    parameter int STALL_CNT_W = 32
);
    logic                   issue_valid;
    logic                   issue_wen;
    logic [4:0]             issue_rd_num;
    logic [4:0]             if_rs1_num;
    logic [4:0]             if_rs2_num;
    logic                   rs1_used;
    logic                   rs2_used;
    logic                   retire_valid;
    logic [4:0]             retire_rd_num;
    logic                   flush;
    logic                   de_ready;
    logic [31:0]            busy_mask;
    logic                   err_underflow;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output issue_valid, issue_wen, issue_rd_num, if_rs1_num, if_rs2_num,
               rs1_used, rs2_used, retire_valid, retire_rd_num, flush,
        input  de_ready, busy_mask, err_underflow, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_wen, issue_rd_num, if_rs1_num, if_rs2_num,
               rs1_used, rs2_used, retire_valid, retire_rd_num, flush,
        output de_ready, busy_mask, err_underflow, stall_cycles
    );
endinterface

// File: rtl/rip_regfile_scoreboard.sv
// Read-after-write hazard scoreboard beside the integer register file.
// Keeps a pending-write counter per architectural register (x1..x31) between
// decode and write-back and produces de_ready, the decode-advance / register
// file read enable. A source whose pending write retires in the same cycle is
// not stalled because the register file forwards wdata on a collision.
// Ports:
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   sb  : slave modport of rip_regfile_scoreboard_if (issue/retire/flush in,
//         de_ready/busy_mask/err_underflow/stall_cycles out)
module rip_regfile_scoreboard #(
    parameter int CNT_W       = 2,
    parameter int STALL_CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    rip_regfile_scoreboard_if.slave  sb
);
    localparam logic [CNT_W-1:0]       CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]       CNT_ONE   = 1;
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = 1;

    logic [CNT_W-1:0]       cnt_q [32];
    logic [CNT_W-1:0]       cnt_d [32];
    logic                   err_q, err_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic [CNT_W-1:0] eff_rs1, eff_rs2, eff_rd;
    logic             haz_rs1, haz_rs2, haz_sat;
    logic             ready, fire, underflow;
    logic [31:0]      busy;

    // Pending count as seen by a reader this cycle: a same-cycle retire of the
    // register is already forwarded, so it no longer counts.
    function automatic logic [CNT_W-1:0] eff_f(input logic [CNT_W-1:0] c, input logic hit);
        return (hit && c != '0) ? c - CNT_ONE : c;
    endfunction

    always_comb begin
        eff_rs1 = eff_f(cnt_q[sb.if_rs1_num],
                        sb.retire_valid && (sb.retire_rd_num == sb.if_rs1_num));
        eff_rs2 = eff_f(cnt_q[sb.if_rs2_num],
                        sb.retire_valid && (sb.retire_rd_num == sb.if_rs2_num));
        eff_rd  = eff_f(cnt_q[sb.issue_rd_num],
                        sb.retire_valid && (sb.retire_rd_num == sb.issue_rd_num));

        haz_rs1 = sb.rs1_used && (sb.if_rs1_num != 5'd0) && (eff_rs1 != '0);
        haz_rs2 = sb.rs2_used && (sb.if_rs2_num != 5'd0) && (eff_rs2 != '0);
        // Another write to a register whose counter is full would overflow it.
        haz_sat = sb.issue_wen && (sb.issue_rd_num != 5'd0) && (eff_rd == CNT_MAX);

        ready = !rst && !sb.flush && !haz_rs1 && !haz_rs2 && !haz_sat;
        fire  = sb.issue_valid && ready;
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i == 0 || sb.flush) begin
                cnt_d[i] = '0;
            end else if (fire && sb.issue_wen && sb.issue_rd_num == 5'(i)) begin
                // A same-cycle retire to this register cancels the increment.
                if (!(sb.retire_valid && sb.retire_rd_num == 5'(i)))
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (sb.retire_valid && sb.retire_rd_num == 5'(i) && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end

        underflow = sb.retire_valid && (sb.retire_rd_num != 5'd0)
                    && (cnt_q[sb.retire_rd_num] == '0) && !sb.flush
                    && !(fire && sb.issue_wen && sb.issue_rd_num == sb.retire_rd_num);
        err_d = err_q | underflow;

        stall_d = stall_q;
        if (sb.issue_valid && !ready && !sb.flush && stall_q != '1)
            stall_d = stall_q + STALL_ONE;

        busy = '0;
        for (int i = 1; i < 32; i++)
            busy[i] = (cnt_q[i] != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                cnt_q[i] <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            for (int i = 0; i < 32; i++)
                cnt_q[i] <= cnt_d[i];
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign sb.de_ready      = ready;
    assign sb.busy_mask     = busy;
    assign sb.err_underflow = err_q;
    assign sb.stall_cycles  = stall_q;
endmodule

// File: tb/tb_rip_regfile_scoreboard.sv
module tb_rip_regfile_scoreboard;
    localparam int CNT_W = 2;
    localparam int SW    = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;
    localparam int SMAX  = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rip_regfile_scoreboard_if #(.STALL_CNT_W(SW)) sb_if ();

    rip_regfile_scoreboard #(.CNT_W(CNT_W), .STALL_CNT_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    typedef struct packed {
        logic          rdy;
        logic [31:0]   busy;
        logic          err;
        logic [SW-1:0] stall;
    } exp_t;

    exp_t q[$];
    int   pend[32];
    bit   m_err;
    int   m_stall;
    int   compared = 0;
    int   mismatched = 0;
    int   cyc_no = 0;

    // Outstanding writes to r as a reader sees them, given this cycle's retire.
    function automatic int eff(input int r, input bit rv, input int rrd);
        int e;
        e = pend[r];
        if (rv && rrd == r && e > 0) e--;
        return e;
    endfunction

    task automatic cyc(input bit r, input bit v, input bit w, input int rd,
                       input int rs1, input bit u1, input int rs2, input bit u2,
                       input bit rv, input int rrd, input bit fl);
        exp_t e;
        bit   rdy, fire, same;
        rst                 = r;
        sb_if.issue_valid   = v;
        sb_if.issue_wen     = w;
        sb_if.issue_rd_num  = 5'(rd);
        sb_if.if_rs1_num    = 5'(rs1);
        sb_if.rs1_used      = u1;
        sb_if.if_rs2_num    = 5'(rs2);
        sb_if.rs2_used      = u2;
        sb_if.retire_valid  = rv;
        sb_if.retire_rd_num = 5'(rrd);
        sb_if.flush         = fl;

        rdy = !r && !fl;
        if (u1 && rs1 != 0 && eff(rs1, rv, rrd) != 0) rdy = 0;
        if (u2 && rs2 != 0 && eff(rs2, rv, rrd) != 0) rdy = 0;
        if (w && rd != 0 && eff(rd, rv, rrd) == MAXC) rdy = 0;
        fire = v && rdy;

        e.rdy = rdy;
        e.busy = '0;
        for (int i = 1; i < 32; i++) e.busy[i] = (pend[i] > 0);
        e.err = m_err;
        e.stall = SW'(m_stall);
        q.push_back(e);

        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) pend[i] = 0;
            m_err = 0;
            m_stall = 0;
        end else begin
            if (v && !rdy && !fl && m_stall < SMAX) m_stall++;
            if (fl) begin
                for (int i = 0; i < 32; i++) pend[i] = 0;
            end else begin
                same = fire && w && rd != 0 && rv && rrd == rd;
                if (!same) begin
                    if (rv && rrd != 0) begin
                        if (pend[rrd] > 0) pend[rrd]--;
                        else m_err = 1;
                    end
                    if (fire && w && rd != 0) pend[rd]++;
                end
            end
        end
        #1;
        cyc_no++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_no, act, req);
        end
    endtask

    // Monitor: compares each cycle's outputs mid-cycle, decoupled from the driver.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("de_ready",      32'(sb_if.de_ready),      32'(e.rdy));
            check("busy_mask",     sb_if.busy_mask,          e.busy);
            check("err_underflow", 32'(sb_if.err_underflow), 32'(e.err));
            check("stall_cycles",  32'(sb_if.stall_cycles),  32'(e.stall));
        end
    end

    initial begin
        int rd, rs1, rs2, rrd, cand;
        bit v, w, u1, u2, rv, fl, r;
        for (int i = 0; i < 32; i++) pend[i] = 0;
        m_err = 0;
        m_stall = 0;
        rst = 1'b1;
        sb_if.issue_valid = 0; sb_if.issue_wen = 0; sb_if.issue_rd_num = 0;
        sb_if.if_rs1_num = 0; sb_if.rs1_used = 0; sb_if.if_rs2_num = 0;
        sb_if.rs2_used = 0; sb_if.retire_valid = 0; sb_if.retire_rd_num = 0;
        sb_if.flush = 0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // x5 producer then a dependent consumer, x5 retires in its third try
        cyc(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 5, 1, 0, 0, 1, 5, 0);
        idle(2);

        // fill x7 to saturation, 4th stalls, then fires with a same-cycle retire
        for (int k = 0; k < 3; k++) cyc(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 7, 0, 0, 0, 0, 1, 7, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        idle(1);

        // x0 is never busy and never errors
        cyc(0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);

        // flush drops x3/x4; a later x3 retire underflows
        cyc(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 3, 1, 4, 1, 0, 0, 1);
        idle(1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        idle(1);

        // reset clears the error; x9 retire+issue at zero, then lone retire
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 9, 0, 0, 0, 0, 1, 9, 0);
        idle(1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        idle(1);

        // randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 99) < 1);
            fl  = ($urandom_range(0, 99) < 3);
            v   = ($urandom_range(0, 99) < 75);
            w   = ($urandom_range(0, 99) < 70);
            rd  = $urandom_range(0, 7);
            rs1 = $urandom_range(0, 7);
            rs2 = $urandom_range(0, 7);
            u1  = $urandom_range(0, 1);
            u2  = $urandom_range(0, 1);
            rv  = ($urandom_range(0, 99) < 45);
            rrd = $urandom_range(0, 7);
            if ($urandom_range(0, 99) < 85) begin
                cand = $urandom_range(1, 7);
                for (int k = 0; k < 7; k++) begin
                    if (pend[cand] > 0) begin
                        rrd = cand;
                        break;
                    end
                    cand = (cand % 7) + 1;
                end
            end
            cyc(r, v, w, rd, rs1, u1, rs2, u2, rv, rrd, fl);
        end
        idle(2);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rip_regfile_scoreboard.md
# rip_regfile_scoreboard

Read-after-write hazard scoreboard that schedules access to the integer register file. It tracks outstanding writes per architectural register between decode and memory-access write-back, and generates `de_ready`, the decode-advance/read-enable for the register file. It sits beside the register file. A source whose pending write retires in the same cycle is not stalled, because the register file forwards `wdata` on a read/write collision.

## Interface
Parameters:
- `CNT_W`, 2: width of each per-register pending counter; max outstanding writes per register = 2^CNT_W − 1.
- `STALL_CNT_W`, 32: width of the stall-cycle performance counter.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  decode holds an instruction wanting to advance.
- `issue_wen`  in  1  that instruction writes a destination register.
- `issue_rd_num`  in  5  its destination register.
- `if_rs1_num`, `if_rs2_num`  in  5 each  its source registers.
- `rs1_used`, `rs2_used`  in  1 each  the corresponding source is actually read.
- `retire_valid`  in  1  write-back of a register-writing instruction this cycle (same cycle as register file `wen`).
- `retire_rd_num`  in  5  register being written back.
- `flush`  in  1  pipeline flush; all in-flight writes are discarded.
- `de_ready`  out  1  decode may advance; register file samples sources.
- `busy_mask`  out  32  bit i = 1 when register i has ≥1 pending write.
- `err_underflow`  out  1  sticky; set when a retire hits a counter already at 0.
- `stall_cycles`  out  STALL_CNT_W  saturating count of cycles with `issue_valid && !de_ready`.

## Operation
- State: 31 counters `cnt[1..31]` (x0 has none and is never busy), `err_underflow`, `stall_cycles`.
- Retire match per source s: `rm_s = retire_valid && retire_rd_num == s`.
- Effective pending: `eff(s) = cnt[s] − rm_s`, floored at 0.
- Source hazard: `rsK_used && if_rsK_num != 0 && eff(if_rsK_num) != 0`.
- Saturation hazard: `issue_wen && issue_rd_num != 0 && eff(issue_rd_num) == max`.
- `de_ready = !rst && !flush && !source hazard(rs1) && !source hazard(rs2) && !saturation hazard`.
  - Combinational from registered state and current inputs.
  - Independent of `issue_valid`, so the register file may still sample when decode is idle.
- `fire = issue_valid && de_ready`.
- Counter update, for each register r ≠ 0:
  - `+1` if `fire && issue_wen && issue_rd_num == r`.
  - `−1` if `retire_valid && retire_rd_num == r && cnt[r] != 0`.
  - Both in the same cycle: unchanged.
- Retire to r with `cnt[r] == 0` and no same-cycle issue to r: counter stays 0 and `err_underflow` is set.
  - Retire with rd = x0 is ignored and never raises an error.
- `flush` has priority over issue and retire: all counters clear to 0 next cycle, the retire is not checked for underflow, and `err_underflow` is unaffected.
- `stall_cycles` increments when `issue_valid && !de_ready && !flush`, and saturates at all-ones.
- `busy_mask[i] = (cnt[i] != 0)`; `busy_mask[0] = 0`.

## Timing
- Reset (`rst` = 1 at a clock edge):
  - All counters 0, `busy_mask` = 0, `err_underflow` = 0, `stall_cycles` = 0.
  - `de_ready` = 0 combinationally while `rst` is high.
- Issue fired in cycle N: `busy_mask` bit set from N+1, and a dependent source stalls from N+1.
- Retire in cycle N:
  - A dependent source sees `de_ready` = 1 already in cycle N (forwarded path).
  - The counter decrements at N+1.
- Back-to-back issue writing and reading the same register (e.g. `addi x5`; `add x6,x5,x5`): the second stalls until the cycle x5 retires.
- `rst` mid-operation discards all pending state exactly like `flush`, and also clears `err_underflow` and `stall_cycles`.

## Test plan
- Reset, then idle → `de_ready` = 1, `busy_mask` = 0, `stall_cycles` = 0.
- Issue rd = x5 in cycle 1; next instruction reads rs1 = x5 with `issue_valid` = 1 in cycles 2–4; retire x5 in cycle 4 → `de_ready` = 0 in cycles 2–3 and 1 in cycle 4; `busy_mask[5]` = 1 in cycles 2–4 and 0 in cycle 5; `stall_cycles` = 2.
- CNT_W = 2: issue rd = x7 three times without retire, then a fourth → fourth stalls (`de_ready` = 0); a retire of x7 in the same cycle → fourth fires and cnt[7] stays 3.
- Issue rd = x0 and read rs1 = x0 → never busy, never stalls; retire x0 with no pending → `err_underflow` stays 0.
- Issue x3 and x4, then `flush` with `issue_valid` = 1 → `de_ready` = 0 in the flush cycle; `busy_mask` = 0 next cycle; a later retire of x3 sets `err_underflow` = 1.
- Retire x9 with cnt[9] = 0 while issuing rd = x9 in the same cycle → cnt[9] unchanged at 0, `err_underflow` = 1 only if no issue; with the issue, `busy_mask[9]` = 0 next cycle and no error.
